// File: rtl/bcd_scan_counter_pkg.sv
// rtl/bcd_scan_counter_pkg.sv - shared BCD constants and digit helpers
package bcd_scan_counter_pkg;

    localparam int         NDIG_DEF = 4;
    localparam logic [3:0] BCD_MAX  = 4'd9;
    localparam logic [3:0] BCD_ZERO = 4'd0;

    // Loaded nibbles above 9 are not valid BCD and collapse to zero.
    function automatic logic [3:0] bcd_sanitize(input logic [3:0] d);
        return (d > BCD_MAX) ? BCD_ZERO : d;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// rtl/bcd_digit.sv - one BCD digit register with carry/borrow out for chaining
module bcd_digit
    import bcd_scan_counter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    input  logic       dec,
    input  logic       ld,
    input  logic [3:0] ld_val,
    output logic [3:0] q,
    output logic       co,
    output logic       bo
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= BCD_ZERO;
        end else if (ld) begin
            q <= bcd_sanitize(ld_val);
        end else if (inc) begin
            q <= (q == BCD_MAX) ? BCD_ZERO : q + 4'd1;
        end else if (dec) begin
            q <= (q == BCD_ZERO) ? BCD_MAX : q - 4'd1;
        end
    end

    assign co = inc & (q == BCD_MAX);
    assign bo = dec & (q == BCD_ZERO);

endmodule

// File: rtl/bcd_scan_counter.sv
// rtl/bcd_scan_counter.sv - chained BCD up/down counter with multiplexed display scan
module bcd_scan_counter
    import bcd_scan_counter_pkg::*;
#(
    parameter int NDIG     = NDIG_DEF,
    parameter int SCAN_DIV = 50000,
    parameter int SEL_LOW  = 0,
    parameter int LZB      = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cnt_en,
    input  logic              up_dn,
    input  logic              load,
    input  logic [4*NDIG-1:0] load_val,
    output logic [4*NDIG-1:0] count,
    output logic              carry,
    output logic [3:0]        indec,
    output logic [NDIG-1:0]   dig_sel,
    output logic              blank
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int IW = $clog2(NDIG);
    localparam logic [NDIG-1:0] SEL_ONE = NDIG'(1);
    localparam logic [NDIG-1:0] SEL_RST = (SEL_LOW != 0) ? ~SEL_ONE : SEL_ONE;

    logic [3:0]      q [NDIG];
    logic [NDIG:0]   inc_c;
    logic [NDIG:0]   dec_c;
    logic [PW-1:0]   presc;
    logic [IW-1:0]   idx;
    logic            upd;
    logic [3:0]      cur_digit;
    logic [NDIG-1:0] sel_hot;
    logic            blank_nxt;
    logic            zacc;

    assign inc_c[0] = cnt_en & up_dn & ~load;
    assign dec_c[0] = cnt_en & ~up_dn & ~load;

    for (genvar g = 0; g < NDIG; g++) begin : g_digit
        bcd_digit u_digit (
            .clk    (clk),
            .rst    (rst),
            .inc    (inc_c[g]),
            .dec    (dec_c[g]),
            .ld     (load),
            .ld_val (load_val[4*g +: 4]),
            .q      (q[g]),
            .co     (inc_c[g+1]),
            .bo     (dec_c[g+1])
        );
        assign count[4*g +: 4] = q[g];
    end

    // A ripple out of the top digit is exactly an all-digit wrap.
    always_ff @(posedge clk) begin
        if (rst) carry <= 1'b0;
        else     carry <= inc_c[NDIG] | dec_c[NDIG];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc <= '0;
            idx   <= '0;
            upd   <= 1'b0;
        end else begin
            upd <= (presc == PW'(SCAN_DIV - 1));
            if (presc == PW'(SCAN_DIV - 1)) begin
                presc <= '0;
                idx   <= (idx == IW'(NDIG - 1)) ? '0 : idx + IW'(1);
            end else begin
                presc <= presc + PW'(1);
            end
        end
    end

    // Walk from the top digit down so zacc means "this digit and all above are zero".
    always_comb begin
        cur_digit = BCD_ZERO;
        sel_hot   = '0;
        blank_nxt = 1'b0;
        zacc      = 1'b1;
        for (int i = NDIG - 1; i >= 0; i--) begin
            zacc = zacc & (q[i] == BCD_ZERO);
            if (idx == IW'(i)) begin
                cur_digit  = q[i];
                sel_hot[i] = 1'b1;
                blank_nxt  = zacc && (i != 0) && (LZB != 0);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            indec   <= BCD_ZERO;
            dig_sel <= SEL_RST;
            blank   <= 1'b0;
        end else if (upd) begin
            indec   <= cur_digit;
            dig_sel <= (SEL_LOW != 0) ? ~sel_hot : sel_hot;
            blank   <= blank_nxt;
        end
    end

endmodule

// File: tb/tb_bcd_scan_counter.sv
// tb/tb_bcd_scan_counter.sv - bench for bcd_scan_counter with vectors, sequences and random model check
module tb_bcd_scan_counter;

    localparam int ND  = 4;
    localparam int S   = 4;
    localparam int MOD = 10000;

    logic        clk = 1'b0;
    logic        rst, cnt_en, up_dn, load;
    logic [15:0] load_val;
    logic [15:0] count_a, count_b;
    logic        carry_a, carry_b, blank_a, blank_b;
    logic [3:0]  indec_a, indec_b, dig_sel_a, dig_sel_b;

    int n_chk = 0;
    int n_fail = 0;

    int mval, n, midx, mdig;
    bit mcarry, mblank;

    always #5 clk = ~clk;

    bcd_scan_counter #(.NDIG(ND), .SCAN_DIV(S), .SEL_LOW(0), .LZB(1)) dut_a (
        .clk(clk), .rst(rst), .cnt_en(cnt_en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .count(count_a), .carry(carry_a), .indec(indec_a),
        .dig_sel(dig_sel_a), .blank(blank_a)
    );

    bcd_scan_counter #(.NDIG(ND), .SCAN_DIV(S), .SEL_LOW(1), .LZB(1)) dut_b (
        .clk(clk), .rst(rst), .cnt_en(cnt_en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .count(count_b), .carry(carry_b), .indec(indec_b),
        .dig_sel(dig_sel_b), .blank(blank_b)
    );

    function automatic int pow10(input int e);
        int r = 1;
        for (int i = 0; i < e; i++) r = r * 10;
        return r;
    endfunction

    function automatic int bcd2int(input logic [15:0] v);
        int r = 0;
        int d;
        for (int i = 0; i < ND; i++) begin
            d = int'(v[4*i +: 4]);
            if (d > 9) d = 0;
            r = r + d * pow10(i);
        end
        return r;
    endfunction

    function automatic int int2bcd(input int v);
        int r = 0;
        for (int i = 0; i < ND; i++) r = r | (((v / pow10(i)) % 10) << (4 * i));
        return r;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: count held as an integer modulo 10^ND; display slot derived from edge count.
    task automatic model_edge(input bit r, input bit ld, input logic [15:0] lv, input bit ce, input bit ud);
        if (r) begin
            mval = 0; mcarry = 0; n = 0; midx = 0; mdig = 0; mblank = 0;
        end else begin
            if (n > 0 && n % S == 0) begin
                midx   = (n / S) % ND;
                mdig   = (mval / pow10(midx)) % 10;
                mblank = (midx > 0) && (mval < pow10(midx));
            end
            if (ld) begin
                mval = bcd2int(lv); mcarry = 0;
            end else if (ce) begin
                if (ud) begin mcarry = (mval == MOD - 1); mval = (mval + 1) % MOD; end
                else    begin mcarry = (mval == 0);       mval = (mval + MOD - 1) % MOD; end
            end else begin
                mcarry = 0;
            end
            n++;
        end
    endtask

    task automatic step(input bit r, input bit ld, input logic [15:0] lv, input bit ce, input bit ud);
        rst = r; load = ld; load_val = lv; cnt_en = ce; up_dn = ud;
        @(posedge clk);
        model_edge(r, ld, lv, ce, ud);
        #1;
        chk("count", int'(count_a), int2bcd(mval));
        chk("count_low", int'(count_b), int2bcd(mval));
        chk("carry", int'(carry_a), int'(mcarry));
        chk("indec", int'(indec_a), mdig);
        chk("blank", int'(blank_a), int'(mblank));
        chk("dig_sel", int'(dig_sel_a), 1 << midx);
        chk("dig_sel_low", int'(dig_sel_b), (~(1 << midx)) & 15);
    endtask

    typedef struct {
        bit          r;
        bit          ld;
        logic [15:0] lv;
        bit          ce;
        bit          ud;
        logic [15:0] ecount;
        bit          ecarry;
    } vec_t;

    vec_t vt[14];
    int   sel4[4] = '{1, 2, 4, 8};
    int   ind4[4] = '{2, 4, 0, 0};
    int   blk4[4] = '{0, 0, 1, 1};

    initial begin
        vt[0]  = '{1, 0, 16'h0000, 0, 0, 16'h0000, 0};
        vt[1]  = '{0, 1, 16'h0999, 0, 0, 16'h0999, 0};
        vt[2]  = '{0, 0, 16'h0000, 1, 1, 16'h1000, 0};
        vt[3]  = '{0, 1, 16'h9999, 0, 0, 16'h9999, 0};
        vt[4]  = '{0, 0, 16'h0000, 1, 1, 16'h0000, 1};
        vt[5]  = '{0, 0, 16'h0000, 1, 0, 16'h9999, 1};
        vt[6]  = '{0, 0, 16'h0000, 0, 0, 16'h9999, 0};
        vt[7]  = '{0, 1, 16'h1234, 1, 1, 16'h1234, 0};
        vt[8]  = '{0, 1, 16'h00A5, 0, 0, 16'h0005, 0};
        vt[9]  = '{0, 0, 16'h0000, 1, 0, 16'h0004, 0};
        vt[10] = '{0, 1, 16'hFFFF, 0, 0, 16'h0000, 0};
        vt[11] = '{0, 0, 16'h0000, 1, 0, 16'h9999, 1};
        vt[12] = '{0, 1, 16'h9999, 1, 1, 16'h9999, 0};
        vt[13] = '{1, 1, 16'h5555, 1, 1, 16'h0000, 0};

        rst = 1; load = 0; load_val = 0; cnt_en = 0; up_dn = 0;

        // Reset for two cycles, then idle through a full scan.
        step(1, 0, 16'h0, 0, 0);
        step(1, 0, 16'h0, 0, 0);
        chk("t1_count", int'(count_a), 0);
        chk("t1_dig_sel", int'(dig_sel_a), 1);
        chk("t1_dig_sel_low", int'(dig_sel_b), 14);
        chk("t1_indec", int'(indec_a), 0);
        chk("t1_blank", int'(blank_a), 0);
        for (int i = 0; i < S * ND + 2; i++) begin
            step(0, 0, 16'h0, 0, 0);
            chk("t1_carry", int'(carry_a), 0);
        end

        // Counter vectors.
        for (int i = 0; i < 14; i++) begin
            step(vt[i].r, vt[i].ld, vt[i].lv, vt[i].ce, vt[i].ud);
            chk($sformatf("vec%0d_count", i), int'(count_a), int'(vt[i].ecount));
            chk($sformatf("vec%0d_carry", i), int'(carry_a), int'(vt[i].ecarry));
        end

        // Scan pattern of 0042 over one full aligned rotation.
        step(1, 0, 16'h0, 0, 0);
        step(0, 1, 16'h0042, 0, 0);
        while (n < 16) step(0, 0, 16'h0, 0, 0);
        for (int k = 0; k < 16; k++) begin
            step(0, 0, 16'h0, 0, 0);
            chk("t4_dig_sel", int'(dig_sel_a), sel4[k / 4]);
            chk("t4_indec", int'(indec_a), ind4[k / 4]);
            chk("t4_blank", int'(blank_a), blk4[k / 4]);
        end

        // Reset mid-slot while counting.
        step(0, 1, 16'h0500, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 0, 16'h0, 1, 1);
        step(1, 0, 16'h0, 1, 1);
        chk("t6_count", int'(count_a), 0);
        chk("t6_carry", int'(carry_a), 0);
        chk("t6_dig_sel", int'(dig_sel_a), 1);
        chk("t6_dig_sel_low", int'(dig_sel_b), 14);
        chk("t6_indec", int'(indec_a), 0);
        for (int i = 0; i < 20; i++) step(0, 0, 16'h0, 1, 0);

        // Random traffic against the model.
        for (int i = 0; i < 500; i++) begin
            step(($urandom_range(0, 59) == 0),
                 ($urandom_range(0, 7) == 0),
                 16'($urandom),
                 ($urandom_range(0, 1) == 1),
                 ($urandom_range(0, 1) == 1));
        end
        // Drive across the wrap points.
        step(0, 1, 16'h9998, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 16'h0, 1, 1);
        for (int i = 0; i < 4; i++) step(0, 0, 16'h0, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
